// File: rtl/div_seq_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_seq_pkg;

  // Divider sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RST_ENABLE       = 1'b0;

endpackage

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// One bit of quotient per cycle; sign handled by dividing magnitudes and
// fixing the signs up on the final cycle.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  div_state_t state_reg, state_next;

  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [2*DATA_W-1:0] dividend_reg, dividend_next;
  logic [DATA_W-1:0]   divisor_reg, divisor_next;
  logic                signed_reg, signed_next;
  logic                sign1_reg, sign1_next;
  logic                sign2_reg, sign2_next;
  logic [2*DATA_W-1:0] result_reg, result_next;
  logic                ready_reg, ready_next;
  logic                busy_reg, busy_next;

  logic [DATA_W-1:0] op1_abs;
  logic [DATA_W-1:0] op2_abs;
  logic [DATA_W:0]   partial;
  logic              take;
  logic [DATA_W-1:0] partial_sub;
  logic [DATA_W-1:0] quot_raw;
  logic [DATA_W-1:0] rem_raw;
  logic [DATA_W-1:0] quot_fix;
  logic [DATA_W-1:0] rem_fix;

  // Magnitudes are only taken for signed divides.
  assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Trial subtraction on the partial remainder with the next dividend bit
  // already shifted in; one bit wider so an all-ones divisor still compares
  // correctly. When the trial succeeds the difference is below the divisor,
  // so its low DATA_W bits are exact.
  assign partial     = {dividend_reg[2*DATA_W-1:DATA_W], dividend_reg[DATA_W-1]};
  assign take        = (partial >= {1'b0, divisor_reg});
  assign partial_sub = partial[DATA_W-1:0] - divisor_reg;

  assign quot_raw = dividend_reg[DATA_W-1:0];
  assign rem_raw  = dividend_reg[2*DATA_W-1:DATA_W];
  // Quotient is negative when operand signs differ; remainder follows the dividend.
  assign quot_fix = (signed_reg && (sign1_reg ^ sign2_reg)) ? -quot_raw : quot_raw;
  assign rem_fix  = (signed_reg && sign1_reg) ? -rem_raw : rem_raw;

  // Next-state, datapath and registered-output selection.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    signed_next   = signed_reg;
    sign1_next    = sign1_reg;
    sign2_next    = sign2_reg;
    result_next   = result_reg;
    ready_next    = ready_reg;
    busy_next     = busy_reg;
    case (state_reg)
      DIV_FREE: begin
        result_next = '0;
        ready_next  = DIV_RESULT_NOT_READY;
        busy_next   = 1'b0;
        cnt_next    = '0;
        if (start_i == DIV_START && !annul_i) begin
          busy_next = 1'b1;
          if (opdata2_i == '0) begin
            state_next = DIV_BYZERO;
          end else begin
            state_next    = DIV_ON;
            dividend_next = {{DATA_W{1'b0}}, op1_abs};
            divisor_next  = op2_abs;
            signed_next   = signed_div_i;
            sign1_next    = opdata1_i[DATA_W-1];
            sign2_next    = opdata2_i[DATA_W-1];
          end
        end
      end
      DIV_BYZERO: begin
        busy_next   = 1'b0;
        result_next = '0;
        if (annul_i) begin
          state_next = DIV_FREE;
          ready_next = DIV_RESULT_NOT_READY;
        end else begin
          state_next = DIV_END;
          ready_next = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_next  = DIV_FREE;
          cnt_next    = '0;
          busy_next   = 1'b0;
          result_next = '0;
          ready_next  = DIV_RESULT_NOT_READY;
        end else if (cnt_reg != CNT_W'(DATA_W)) begin
          if (take) begin
            dividend_next = {partial_sub, dividend_reg[DATA_W-2:0], 1'b1};
          end else begin
            dividend_next = {dividend_reg[2*DATA_W-2:0], 1'b0};
          end
          cnt_next = cnt_reg + CNT_W'(1);
        end else begin
          state_next  = DIV_END;
          result_next = {rem_fix, quot_fix};
          ready_next  = DIV_RESULT_READY;
          busy_next   = 1'b0;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_next  = DIV_FREE;
          result_next = '0;
          ready_next  = DIV_RESULT_NOT_READY;
          cnt_next    = '0;
        end
      end
      default: begin
        state_next = DIV_FREE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == DIV_RST_ENABLE) begin
      state_reg <= DIV_FREE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == DIV_RST_ENABLE) begin
      cnt_reg      <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      signed_reg   <= 1'b0;
      sign1_reg    <= 1'b0;
      sign2_reg    <= 1'b0;
      result_reg   <= '0;
      ready_reg    <= DIV_RESULT_NOT_READY;
      busy_reg     <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      signed_reg   <= signed_next;
      sign1_reg    <= sign1_next;
      sign2_reg    <= sign2_next;
      result_reg   <= result_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;
  assign busy_o   = busy_reg;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table plus hand-written annul/reset sequences.
module tb_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic         annul_i = 1'b0;
  logic         signed_div_i = 1'b0;
  logic [W-1:0] opdata1_i = '0;
  logic [W-1:0] opdata2_i = '0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  div_seq #(.DATA_W(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start a divide, scramble the operand inputs after the sampling edge,
  // and check latency, busy profile, result, hold in END and release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q,
                         input logic [31:0] r, input int lat);
    int   edges;
    int   bad;
    logic got;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    edges = 0;
    bad   = 0;
    got   = 1'b0;
    while (!got && edges < 60) begin
      tick();
      edges++;
      if (edges == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
      if (ready_o === 1'b1) got = 1'b1;
      else if (busy_o !== 1'b1 || result_o !== '0) bad++;
    end
    check($sformatf("%s latency", tag), 64'(edges), 64'(lat));
    check($sformatf("%s busy before ready", tag), 64'(bad), 64'd0);
    check($sformatf("%s busy at ready", tag), {63'd0, busy_o}, 64'd0);
    check($sformatf("%s result", tag), result_o, {r, q});
    $display("txn %s: sgn=%0d a=%h b=%h -> rem=%h quot=%h after %0d edges",
             tag, sgn, a, b, result_o[63:32], result_o[31:0], edges);
    tick();
    check($sformatf("%s hold ready", tag), {63'd0, ready_o}, 64'd1);
    check($sformatf("%s hold result", tag), result_o, {r, q});
    start_i = 1'b0;
    tick();
    check($sformatf("%s release ready", tag), {63'd0, ready_o}, 64'd0);
    check($sformatf("%s release result", tag), result_o, 64'd0);
  endtask

  initial begin
    int bad;
    int edges;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD,   32'hFFFFFFFF,   34};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h00000000,   34};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFF,   32'h00000000,   34};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          2};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          34};
    vecs[6]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          34};
    vecs[7]  = '{1'b0, 32'd15,         32'd4,          32'd3,          32'd3,          34};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          34};
    vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          34};
    vecs[10] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   34};
    vecs[11] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   34};

    // Reset values, and reset dominating a clock edge with start raised.
    #1 rst = 1'b0;
    #2;
    check("reset result", result_o, 64'd0);
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset busy", {63'd0, busy_o}, 64'd0);
    start_i   = 1'b1;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    tick();
    check("in reset busy", {63'd0, busy_o}, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_div($sformatf("v%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
              vecs[i].q, vecs[i].r, vecs[i].lat);
    end

    // Annul during ON at edge 10: no result, then a fresh divide works.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (9) tick();
    check("annul on pre busy", {63'd0, busy_o}, 64'd1);
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    check("annul on busy", {63'd0, busy_o}, 64'd0);
    check("annul on ready", {63'd0, ready_o}, 64'd0);
    bad = 0;
    repeat (40) begin
      tick();
      if (ready_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    check("annul on quiet", 64'(bad), 64'd0);
    $display("txn annul-on: aborted 100/7 at edge 10");
    run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34);

    // Annul in FREE blocks the start; dropping it lets the start through.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    repeat (3) tick();
    check("annul free busy", {63'd0, busy_o}, 64'd0);
    annul_i = 1'b0;
    tick();
    check("annul free released busy", {63'd0, busy_o}, 64'd1);
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    check("annul free idle", {62'd0, busy_o, ready_o}, 64'd0);
    $display("txn annul-free: start held off while annul high");

    // Annul in BYZERO yields no result.
    opdata1_i = 32'd5;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    tick();
    check("byzero busy", {63'd0, busy_o}, 64'd1);
    annul_i = 1'b1;
    tick();
    check("annul byzero ready", {63'd0, ready_o}, 64'd0);
    check("annul byzero busy", {63'd0, busy_o}, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    $display("txn annul-byzero: 5/0 aborted");

    // Annul in END is ignored; only start_i=0 leaves END.
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    edges = 0;
    while (ready_o !== 1'b1 && edges < 60) begin
      tick();
      edges++;
    end
    check("end wait latency", 64'(edges), 64'd34);
    annul_i = 1'b1;
    tick();
    check("annul end ready", {63'd0, ready_o}, 64'd1);
    check("annul end result", result_o, {32'd0, 32'd3});
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    check("annul end release", {63'd0, ready_o}, 64'd0);
    $display("txn annul-end: result held through annul");

    // Asynchronous reset mid-divide, then a clean divide afterwards.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (20) tick();
    check("pre reset busy", {63'd0, busy_o}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async reset busy", {63'd0, busy_o}, 64'd0);
    check("async reset ready", {63'd0, ready_o}, 64'd0);
    check("async reset result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    $display("txn async-reset: reset at edge 20");
    run_div("post reset 15/4", 1'b0, 32'd15, 32'd4, 32'd3, 32'd3, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
